// File: rtl/dm_resp_if.sv
// MEM-stage data-memory request/response bundle between the pipeline (master)
// and the data-memory responder (slave).
interface dm_resp_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              err;

    modport master (
        output addr, re, we, wr_data,
        input  rd_data, rd_valid, busy, err
    );

    modport slave (
        input  addr, re, we, wr_data,
        output rd_data, rd_valid, busy, err
    );
endinterface

// File: rtl/dm_resp.sv
// Data-memory responder: multi-cycle read pipeline, posted one-entry write buffer
// with read-after-write forwarding. Define DM_RESET_CLEAR_EN for a post-reset zero sweep.
module dm_resp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 2
) (
    input  logic      clk,
    input  logic      rst,
    dm_resp_if.slave  dm
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DM_RESET_CLEAR_EN
    typedef enum logic [1:0] {IDLE, RD_WAIT, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD_WAIT} state_t;
`endif

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] snap;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
`ifdef DM_RESET_CLEAR_EN
    logic [IDX_W-1:0]  clr_cnt;
`endif

    logic              busy;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic              req_rd;
    logic              req_wr;
    logic              req_both;
    logic [DATA_W-1:0] rd_value;

    // Upper address bits nonzero means out of range; the index never aliases.
    assign idx      = dm.addr[IDX_W-1:0];
    assign oor      = (dm.addr >> IDX_W) != '0;
    assign req_rd   = dm.re && !dm.we && !busy;
    assign req_wr   = dm.we && !dm.re && !busy;
    assign req_both = dm.re && dm.we && !busy;
    assign rd_value = oor ? '0 :
                      (wb_valid && wb_idx == idx) ? wb_data : mem[idx];
    assign dm.busy  = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef DM_RESET_CLEAR_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_rd && RD_LAT > 1) state_nx = RD_WAIT;
            RD_WAIT: if (lat_cnt == 4'd1) state_nx = IDLE;
`ifdef DM_RESET_CLEAR_EN
            CLEAR:   if (clr_cnt == IDX_W'(DEPTH - 1)) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // The buffer owns the write port except during the sweep; nothing commits under rst.
    always_comb begin
        busy      = (state == RD_WAIT);
        mem_we    = wb_valid && !rst;
        mem_widx  = wb_idx;
        mem_wdata = wb_data;
`ifdef DM_RESET_CLEAR_EN
        if (state == CLEAR) begin
            busy      = !rst;
            mem_we    = !rst;
            mem_widx  = clr_cnt;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm.rd_data  <= '0;
            dm.rd_valid <= 1'b0;
            dm.err      <= 1'b0;
            lat_cnt     <= '0;
            snap        <= '0;
            wb_valid    <= 1'b0;
            wb_idx      <= '0;
            wb_data     <= '0;
`ifdef DM_RESET_CLEAR_EN
            clr_cnt     <= '0;
`endif
        end else begin
            dm.rd_valid <= 1'b0;
            dm.err      <= req_both || ((req_rd || req_wr) && oor);

            // The old entry commits this edge regardless; a new write simply refills it.
            if (req_wr && !oor) begin
                wb_valid <= 1'b1;
                wb_idx   <= idx;
                wb_data  <= dm.wr_data;
            end else begin
                wb_valid <= 1'b0;
            end

            if (req_rd) begin
                snap <= rd_value;
                if (RD_LAT == 1) begin
                    dm.rd_valid <= 1'b1;
                    dm.rd_data  <= rd_value;
                end else begin
                    lat_cnt <= 4'(RD_LAT - 1);
                end
            end

            if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    dm.rd_valid <= 1'b1;
                    dm.rd_data  <= snap;
                end
            end

`ifdef DM_RESET_CLEAR_EN
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
`endif
        end
    end
endmodule
